// File: rtl/fadd_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_share_arb
//  Purpose  : Round-robin arbiter/sequencer sharing one floating-point add
//             datapath + controller among NREQ requesters. Latches the winning
//             operand pair, releases the adder controller from reset, waits for
//             DONE (or a timeout), then returns the sum over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module fadd_share_arb #(
  parameter int NREQ    = 4,   // number of requesters, 2..8
  parameter int WIDTH   = 32,  // operand/result width
  parameter int TIMEOUT = 64   // max WAIT cycles before an error response
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  // requester side
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [NREQ-1:0]         rsp_valid_o,
  input  logic [NREQ-1:0]         rsp_ready_i,
  output logic [WIDTH-1:0]        rsp_data_o,
  output logic                    rsp_err_o,
  // adder datapath / controller side
  output logic                    fa_rst_o,
  output logic [WIDTH-1:0]        fa_a_o,
  output logic [WIDTH-1:0]        fa_b_o,
  input  logic                    fa_done_i,
  input  logic [WIDTH-1:0]        fa_result_i,
  // status
  output logic                    busy_o
);

  // Pointer/grant width; the extra bit in C_NREQ lets ptr+k be formed without
  // overflow before the single modulo subtraction.
  localparam int              PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              CW         = $clog2(TIMEOUT);
  localparam logic [PW:0]     C_NREQ     = (PW+1)'(NREQ);
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] C_ONE      = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and next-state values
  // --------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [PW-1:0]     ptr_q,       ptr_d;
  logic [PW-1:0]     gnt_q,       gnt_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [WIDTH-1:0]  fa_a_q,      fa_a_d;
  logic [WIDTH-1:0]  fa_b_q,      fa_b_d;
  logic [WIDTH-1:0]  rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              fa_rst_q,    fa_rst_d;
  logic              busy_q,      busy_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

  // --------------------------------------------------------------------------
  // Unpacked view of the requester operand buses
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  w_req_a [NREQ];
  logic [WIDTH-1:0]  w_req_b [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_req_a[gi] = req_a_i[gi*WIDTH +: WIDTH];
      assign w_req_b[gi] = req_b_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin winner search
  // --------------------------------------------------------------------------
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [NREQ-1:0]   w_win_onehot;
  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_idx;

  // Scan (ptr+1)..(ptr+NREQ) mod NREQ and keep the first active requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (w_sum >= C_NREQ) begin
        w_sum = w_sum - C_NREQ;
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_onehot = w_found ? (C_ONE << w_win) : '0;

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  // IDLE accepts the winner, WAIT runs the adder under a cycle budget,
  // RESP presents the result until the granted requester takes it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    fa_a_d      = fa_a_q;
    fa_b_d      = fa_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fa_rst_d    = fa_rst_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      S_IDLE: begin
        // req_ready is asserted to the winner, so a winner means a transfer.
        if (w_found) begin
          fa_a_d   = w_req_a[w_win];
          fa_b_d   = w_req_b[w_win];
          gnt_d    = w_win;
          ptr_d    = w_win;
          cnt_d    = '0;
          fa_rst_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // DONE takes priority over a timeout landing on the same cycle.
        if (fa_done_i) begin
          rsp_data_d  = fa_result_i;
          rsp_err_d   = 1'b0;
          fa_rst_d    = 1'b1;
          rsp_valid_d = C_ONE << gnt_q;
          state_d     = S_RESP;
        end else if (cnt_q == C_CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          fa_rst_d    = 1'b1;
          rsp_valid_d = C_ONE << gnt_q;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        // Only the granted requester's ready bit releases the response.
        if (rsp_ready_i[gnt_q]) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        rsp_valid_d = '0;
        busy_d      = 1'b0;
        fa_rst_d    = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers with synchronous reset
  // --------------------------------------------------------------------------
  // Reset aborts any operation in flight: no response, adder parked.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      fa_a_q      <= '0;
      fa_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      fa_rst_q    <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      fa_a_q      <= fa_a_d;
      fa_b_q      <= fa_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      fa_rst_q    <= fa_rst_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs; handshake/status outputs are forced inactive while reset is held
  // so they are well defined even before the first reset edge.
  // --------------------------------------------------------------------------
  assign req_ready_o = (state_q == S_IDLE && !reset_i) ? w_win_onehot : '0;
  assign rsp_valid_o = reset_i ? '0 : rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign fa_rst_o    = fa_rst_q | reset_i;
  assign fa_a_o      = fa_a_q;
  assign fa_b_o      = fa_b_q;
  assign busy_o      = busy_q & ~reset_i;

endmodule
`default_nettype wire

// File: tb/tb_fadd_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fadd_share_arb
//  Purpose  : Self-checking bench for fadd_share_arb. Models requesters and a
//             behavioural adder controller (DONE after a chosen latency), and
//             predicts grants, latency and responses from round-robin rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fadd_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 64;
  localparam int NEVER = 1000;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      rsp_data, fa_a, fa_b, fa_result;
  logic              rsp_err, fa_rst, fa_done, busy;

  int                n_tests = 0;
  int                n_fail  = 0;
  int                lat     = 0;
  int                ptr_m   = 0;
  logic [7:0]        mctr;
  logic [W-1:0]      ma [NREQ];
  logic [W-1:0]      mb [NREQ];
  logic [W-1:0]      last_data;

  always #5 clock = ~clock;

  fadd_share_arb #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .fa_rst_o    (fa_rst),
    .fa_a_o      (fa_a),
    .fa_b_o      (fa_b),
    .fa_done_i   (fa_done),
    .fa_result_i (fa_result),
    .busy_o      (busy)
  );

  // Single-precision <-> double conversion for normal numbers only.
  function automatic real s2r(input logic [31:0] a);
    if (a[30:0] == 31'd0) return 0.0;
    return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real        r;
    logic [63:0] d;
    r = s2r(a) + s2r(b);
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Adder controller model: counts cycles out of reset, DONE after 'lat'.
  always @(posedge clock) begin
    if (fa_rst) mctr <= 8'd0;
    else if (mctr != 8'hFF) mctr <= mctr + 8'd1;
  end

  always_comb begin
    fa_done   = !fa_rst && (int'(mctr) >= lat);
    fa_result = fa_done ? fadd(fa_a, fa_b) : 32'hDEADBEEF;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  task automatic arm(input int i);
    ma[i] = rand_float();
    mb[i] = rand_float();
    req_a[i*W +: W] = ma[i];
    req_b[i*W +: W] = mb[i];
    req_valid[i]    = 1'b1;
  endtask

  // Round-robin rule: first active requester after the last winner.
  function automatic int winner(input int p, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // One complete transaction starting from IDLE at a negedge.
  task automatic do_op(input int lat_i, input int bp, input bit rearm, output int w);
    int              n, en;
    logic [W-1:0]    ed, ea, eb;
    logic            ee;
    logic [NREQ-1:0] oh;
    lat = lat_i;
    if (req_valid == '0) arm($urandom_range(0, NREQ-1));
    #1;
    w  = winner(ptr_m, req_valid);
    oh = NREQ'(1 << w);
    check("req_ready", 64'(req_ready), 64'(oh));
    check("fa_rst_idle", 64'(fa_rst), 64'd1);
    ea = ma[w];
    eb = mb[w];
    ee = (lat_i >= TO);
    ed = ee ? 32'd0 : fadd(ea, eb);
    en = ee ? TO : lat_i + 1;
    @(negedge clock);
    ptr_m = w;
    if (rearm) arm(w);
    else req_valid[w] = 1'b0;
    check("fa_ops", {fa_a, fa_b}, {ea, eb});
    check("wait_ctl", 64'({busy, fa_rst, req_ready}), 64'({1'b1, 1'b0, 4'b0}));
    n = 0;
    while (rsp_valid == '0 && n < TO + 8) begin
      @(negedge clock);
      n++;
    end
    check("latency", 64'(n), 64'(en));
    check("rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'({oh, ee, ed}));
    check("resp_ctl", 64'({busy, fa_rst, req_ready}), 64'({1'b1, 1'b1, 4'b0}));
    last_data = rsp_data;
    for (int k = 0; k < bp; k++) begin
      rsp_ready = NREQ'($urandom) & ~oh;
      @(negedge clock);
      check("hold", 64'({rsp_valid, rsp_err, rsp_data, req_ready}), 64'({oh, ee, ed, 4'b0}));
    end
    rsp_ready = oh | NREQ'($urandom);
    @(negedge clock);
    rsp_ready = '0;
    check("done_ctl", 64'({busy, fa_rst, rsp_valid}), 64'({1'b0, 1'b1, 4'b0}));
  endtask

  int order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    int w;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) arm(i);
    repeat (3) @(negedge clock);
    check("rst_ops", {fa_a, fa_b}, 64'd0);
    check("rst_rsp", 64'({rsp_err, rsp_data}), 64'd0);
    check("rst_hs", 64'({req_ready, rsp_valid}), 64'd0);
    check("rst_ctl", 64'({fa_rst, busy}), 64'b10);
    req_valid = '0;
    reset     = 1'b0;
    ptr_m     = 0;
    @(negedge clock);

    // single operation: 1.0 + 2.0
    req_a[0 +: W] = 32'h3F800000;  ma[0] = 32'h3F800000;
    req_b[0 +: W] = 32'h40000000;  mb[0] = 32'h40000000;
    req_valid[0]  = 1'b1;
    do_op(3, 0, 1'b0, w);
    check("single_w", 64'(w), 64'd0);
    check("single_sum", 64'(last_data), 64'h40400000);

    // fairness with all requesters held active, backpressure on one op
    for (int i = 0; i < NREQ; i++) arm(i);
    for (int k = 0; k < 8; k++) begin
      do_op($urandom_range(0, 6), (k == 1) ? 5 : $urandom_range(0, 2), 1'b1, w);
      check("order", 64'(w), 64'(order[k]));
    end
    req_valid = '0;

    // timeout and DONE coinciding with the timeout cycle
    arm(1);
    do_op(NEVER, 1, 1'b0, w);
    arm(3);
    do_op(TO - 1, 0, 1'b0, w);

    // reset while waiting at cnt=3
    lat = NEVER;
    arm(2);
    @(negedge clock);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_wait", 64'({busy, fa_rst, rsp_valid, req_ready}), 64'({1'b0, 1'b1, 4'b0, 4'b0}));
    reset = 1'b0;
    ptr_m = 0;
    repeat (2) @(negedge clock);
    check("rst_norsp", 64'({busy, rsp_valid}), 64'd0);
    arm(2);
    do_op(2, 1, 1'b0, w);
    check("rst_next_w", 64'(w), 64'd2);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) arm(i);
      end
      do_op(($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 8),
            $urandom_range(0, 3), 1'($urandom), w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
